mat_mat_mul_param: RTL

Parametrised fixed-point square matrix multiplier computing C = A·B, or C = A·B + C_prev in accumulate mode, for DIM×DIM signed Qm.FRAC_BITS operands. It sits in the render pipeline's math stage, where it composes model/view/projection transforms and chains transform products. It replaces the fixed 4×4 multiplier with:
- configurable dimension;
- valid/ready handshakes with output backpressure;
- round-to-nearest rescaling;
- saturation with an overflow flag;
- per-transaction accumulate and transpose-B modes.

---
 rtl/mat_mat_mul_param_if.sv | 27 ++
 rtl/mat_mat_mul_param.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mat_mat_mul_param_if.sv
// Handshake bundle for mat_mat_mul_param.
// Operand/result matrices are row-major [row][col].
interface mat_mat_mul_param_if #(
    parameter int DIM       = 4,
    parameter int DATAWIDTH = 18
);
    logic signed [DATAWIDTH-1:0] A [DIM][DIM];
    logic signed [DATAWIDTH-1:0] B [DIM][DIM];
    logic                        i_acc;
    logic                        i_transpose_b;
    logic                        i_valid;
    logic                        i_ready;
    logic signed [DATAWIDTH-1:0] C [DIM][DIM];
    logic                        o_sat;
    logic                        o_valid;
    logic                        o_ready;

    modport master (
        output A, B, i_acc, i_transpose_b, i_valid, o_ready,
        input  i_ready, C, o_sat, o_valid
    );

    modport slave (
        input  A, B, i_acc, i_transpose_b, i_valid, o_ready,
        output i_ready, C, o_sat, o_valid
    );
endinterface

// File: rtl/mat_mat_mul_param.sv
// Fixed-point DIMxDIM matrix multiplier: C = A*B (optionally B transposed, optionally + C_prev),
// one k-slice per cycle, round-half-up rescale and saturation to DATAWIDTH.
module mat_mat_mul_param #(
    parameter int DIM       = 4,
    parameter int DATAWIDTH = 18,
    parameter int FRAC_BITS = 8,
    parameter int ACCWIDTH  = 2*DATAWIDTH + $clog2(DIM) + 1
) (
    input logic                clk,
    input logic                rst,
    mat_mat_mul_param_if.slave bus
);
    localparam int KW = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int PW = 2*DATAWIDTH;
    localparam logic signed [ACCWIDTH:0] HALF = (ACCWIDTH+1)'(1) <<< (FRAC_BITS-1);
    localparam logic signed [ACCWIDTH:0] MAXV = (ACCWIDTH+1)'(2**(DATAWIDTH-1) - 1);
    localparam logic signed [ACCWIDTH:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, COMPUTE, ROUND, OUTPUT} state_t;
    state_t state, state_nxt;

    logic signed [DATAWIDTH-1:0] a_r   [DIM][DIM];
    logic signed [DATAWIDTH-1:0] b_r   [DIM][DIM];
    logic                        trans_r;
    logic signed [ACCWIDTH-1:0]  acc   [DIM][DIM];
    logic signed [PW-1:0]        prod  [DIM][DIM];
    logic signed [DATAWIDTH-1:0] c_r   [DIM][DIM];
    logic signed [DATAWIDTH-1:0] c_nxt [DIM][DIM];
    logic        [DATAWIDTH:0]   sv    [DIM][DIM];
    logic                        sat_r, sat_nxt;
    logic                        o_valid_r, i_ready_r;
    logic        [KW-1:0]        k;
    logic                        accept;

    function automatic logic signed [ACCWIDTH:0] round_half_up(input logic signed [ACCWIDTH-1:0] a);
        return ((ACCWIDTH+1)'(a) + HALF) >>> FRAC_BITS;
    endfunction

    // Returns {clamped, value}
    function automatic logic [DATAWIDTH:0] saturate(input logic signed [ACCWIDTH:0] r);
        if (r > MAXV)
            return {1'b1, MAXV[DATAWIDTH-1:0]};
        else if (r < MINV)
            return {1'b1, MINV[DATAWIDTH-1:0]};
        else
            return {1'b0, r[DATAWIDTH-1:0]};
    endfunction

    assign accept      = (state == IDLE) && bus.i_valid && i_ready_r;
    assign bus.i_ready = i_ready_r;
    assign bus.o_valid = o_valid_r;
    assign bus.o_sat   = sat_r;
    assign bus.C       = c_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = COMPUTE;
            COMPUTE: if (k == KW'(DIM-1)) state_nxt = ROUND;
            ROUND:   state_nxt = OUTPUT;
            OUTPUT:  if (bus.o_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture: only the accept edge loads, so inputs outside IDLE are ignored
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r     <= bus.A;
            b_r     <= bus.B;
            trans_r <= bus.i_transpose_b;
        end
    end

    always_comb begin
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                prod[i][j] = PW'(a_r[i][k]) * PW'(trans_r ? b_r[j][k] : b_r[k][j]);
    end

    always_comb begin
        sat_nxt = 1'b0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                sv[i][j]    = saturate(round_half_up(acc[i][j]));
                c_nxt[i][j] = sv[i][j][DATAWIDTH-1:0];
                sat_nxt     = sat_nxt | sv[i][j][DATAWIDTH];
            end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k         <= '0;
            i_ready_r <= 1'b0;
            o_valid_r <= 1'b0;
            sat_r     <= 1'b0;
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    acc[i][j] <= '0;
                    c_r[i][j] <= '0;
                end
        end else begin
            i_ready_r <= (state_nxt == IDLE);
            o_valid_r <= (state_nxt == OUTPUT);
            k         <= (state == COMPUTE && k != KW'(DIM-1)) ? k + 1'b1 : '0;
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    if (accept)
                        acc[i][j] <= bus.i_acc ? (ACCWIDTH'(c_r[i][j]) <<< FRAC_BITS) : '0;
                    else if (state == COMPUTE)
                        acc[i][j] <= acc[i][j] + ACCWIDTH'(prod[i][j]);
                end
            // Rescale boundary: C and o_sat change only here
            if (state == ROUND) begin
                c_r   <= c_nxt;
                sat_r <= sat_nxt;
            end
        end
    end
endmodule
